// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Owns the PC, sequences instruction-memory reads into an
//            instruction register, and applies (possibly in-flight) redirects.
// Revision : 1.0 - initial release
// ============================================================================

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic        fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]  r_state,    w_state_nxt;
    logic [31:0] r_pc,       w_pc_nxt;
    logic [31:0] r_addr,     w_addr_nxt;
    logic [31:0] r_instr,    w_instr_nxt;
    logic [31:0] r_instr_pc, w_instr_pc_nxt;
    logic        r_valid,    w_valid_nxt;
    logic        r_fault,    w_fault_nxt;
    logic        r_discard,  w_discard_nxt;

    logic        w_redir_ok;
    logic        w_redir_bad;

    assign w_redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
    assign w_redir_bad = redirect && (redirect_pc[1:0] != 2'b00);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_addr_nxt     = r_addr;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_fault_nxt    = r_fault;
        w_discard_nxt  = r_discard;

        case (r_state)
            S_IDLE: begin
                if (w_redir_bad) begin
                    w_state_nxt = S_FAULT;
                end else if (w_redir_ok) begin
                    w_pc_nxt = redirect_pc;
                    if (run) begin
                        w_state_nxt = S_FETCH;
                        w_addr_nxt  = redirect_pc;
                    end
                end else if (run) begin
                    w_state_nxt = S_FETCH;
                    w_addr_nxt  = r_pc;
                end
            end

            S_FETCH: begin
                if (w_redir_bad) begin
                    // The outstanding read is abandoned here and nowhere else.
                    w_state_nxt = S_FAULT;
                end else if (r_discard) begin
                    if (w_redir_ok) begin
                        w_pc_nxt = redirect_pc;
                    end
                    if (imem_ack) begin
                        w_discard_nxt = 1'b0;
                        if (run) begin
                            w_state_nxt = S_FETCH;
                            w_addr_nxt  = w_pc_nxt;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end else if (w_redir_ok) begin
                    w_pc_nxt = redirect_pc;
                    if (imem_ack) begin
                        if (run) begin
                            w_state_nxt = S_FETCH;
                            w_addr_nxt  = redirect_pc;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        // Request cannot be withdrawn; swallow its data later.
                        w_discard_nxt = 1'b1;
                    end
                end else if (imem_ack) begin
                    w_instr_nxt    = imem_rdata;
                    w_instr_pc_nxt = r_addr;
                    w_pc_nxt       = r_addr + 32'd4;
                    w_valid_nxt    = 1'b1;
                    w_state_nxt    = S_HOLD;
                end
            end

            S_HOLD: begin
                if (w_redir_bad) begin
                    w_state_nxt = S_FAULT;
                end else if (w_redir_ok) begin
                    w_pc_nxt    = redirect_pc;
                    w_valid_nxt = 1'b0;
                    if (run) begin
                        w_state_nxt = S_FETCH;
                        w_addr_nxt  = redirect_pc;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (instr_ready) begin
                    w_valid_nxt = 1'b0;
                    if (run) begin
                        w_state_nxt = S_FETCH;
                        w_addr_nxt  = r_pc;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_FAULT;
            end
        endcase

        if (w_state_nxt == S_FAULT) begin
            w_fault_nxt   = 1'b1;
            w_valid_nxt   = 1'b0;
            w_discard_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_instr    <= 32'd0;
            r_instr_pc <= 32'd0;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_addr     <= w_addr_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_fault    <= w_fault_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_addr;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign pc          = r_pc;
    assign fault       = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer with a delay-programmable
//            memory model and an instruction scoreboard.
// Revision : 1.0 - initial release
// ============================================================================

module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_ready = 1'b0;
    logic        imem_req, imem_ack, instr_valid, fault;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, pc;

    logic        w_req, w_valid, w_fault;
    logic [31:0] w_addr, w_instr, w_instr_pc, w_pc;

    int  mem_delay = 0;
    int  wait_cnt = 0;
    bit  ack_force = 1'b0;
    int  n_cmp = 0;
    int  n_bad = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[31:16]};
    endfunction

    assign imem_ack   = ack_force | (imem_req & (wait_cnt >= mem_delay));
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .pc(pc), .fault(fault)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .reset(reset), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(mem_word(w_addr)),
        .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(instr_ready),
        .pc(w_pc), .fault(w_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        instr_ready = 1'b0; ack_force = 1'b0; mem_delay = 0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'd0 || instr_pc !== 32'd0) begin n_bad++; $display("FAIL reset_instr: got %h/%h want 0/0", instr, instr_pc); end
        n_cmp++; if (pc !== 32'd0 || fault !== 1'b0) begin n_bad++; $display("FAIL reset_pc_fault: got %h/%b want 0/0", pc, fault); end
    endtask

    task automatic test_basic();
        logic exp_req;
        do_reset();
        run = 1'b1; instr_ready = 1'b1; mem_delay = 0;
        for (int k = 0; k < 3; k++) sb.push_back({32'(4 * k), mem_word(32'(4 * k))});
        for (int c = 1; c <= 6; c++) begin
            tick();
            exp_req = 1'((c % 2) == 1);
            n_cmp++; if (imem_req !== exp_req) begin n_bad++; $display("FAIL basic_req c%0d: got %b want %b", c, imem_req, exp_req); end
            if (exp_req) begin
                n_cmp++; if (imem_addr !== 32'(2 * (c - 1))) begin n_bad++; $display("FAIL basic_addr c%0d: got %h want %h", c, imem_addr, 32'(2 * (c - 1))); end
            end else begin
                n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid c%0d: got %b want 1", c, instr_valid); end
            end
            if (instr_valid && instr_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL basic_sb: got unexpected %h@%h want none", instr, instr_pc); end
                else begin
                    exp_e = sb.pop_front();
                    if ({instr_pc, instr} !== exp_e) begin n_bad++; $display("FAIL basic_sb: got %h want %h", {instr_pc, instr}, exp_e); end
                end
            end
            if (c == 5) run = 1'b0;
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL basic_left: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        run = 1'b1; instr_ready = 1'b0; mem_delay = 0;
        sb.push_back({32'h0, mem_word(32'h0)});
        sb.push_back({32'h4, mem_word(32'h4)});
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL bp_req1: got %b/%h want 1/0", imem_req, imem_addr); end
        for (int c = 2; c <= 7; c++) begin
            tick();
            n_cmp++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin
                n_bad++; $display("FAIL bp_hold c%0d: got v%b r%b %h@%h want v1 r0 %h@0", c, instr_valid, imem_req, instr, instr_pc, mem_word(32'h0));
            end
        end
        instr_ready = 1'b1;
        n_cmp++; exp_e = sb.pop_front();
        if ({instr_pc, instr} !== exp_e) begin n_bad++; $display("FAIL bp_sb0: got %h want %h", {instr_pc, instr}, exp_e); end
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_bad++; $display("FAIL bp_req2: got %b/%h want 1/4", imem_req, imem_addr); end
        run = 1'b0;
        tick();
        n_cmp++;
        if (!(instr_valid && instr_ready)) begin n_bad++; $display("FAIL bp_sb1: got valid %b want 1", instr_valid); end
        else begin
            exp_e = sb.pop_front();
            if ({instr_pc, instr} !== exp_e) begin n_bad++; $display("FAIL bp_sb1: got %h want %h", {instr_pc, instr}, exp_e); end
        end
        tick();
        n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle: got r%b v%b want r0 v0", imem_req, instr_valid); end
    endtask

    task automatic test_redirect_outstanding();
        bit done;
        do_reset();
        run = 1'b1; instr_ready = 1'b1; mem_delay = 3;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_ack !== 1'b0) begin n_bad++; $display("FAIL ro_wait: got req%b ack%b want req1 ack0", imem_req, imem_ack); end
        redirect = 1'b1; redirect_pc = 32'h100;
        sb.push_back({32'h100, mem_word(32'h100)});
        tick();
        redirect = 1'b0;
        n_cmp++; if (pc !== 32'h100) begin n_bad++; $display("FAIL ro_pc: got %h want 100", pc); end
        for (int c = 2; c <= 4; c++) begin
            if (c > 2) tick();
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                n_bad++; $display("FAIL ro_hold c%0d: got r%b %h v%b want r1 0 v0", c, imem_req, imem_addr, instr_valid);
            end
        end
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_bad++; $display("FAIL ro_newreq: got %b/%h want 1/100", imem_req, imem_addr); end
        run = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            tick();
            if (instr_valid && instr_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL ro_sb: got unexpected %h@%h want none", instr, instr_pc); end
                else begin
                    exp_e = sb.pop_front();
                    if ({instr_pc, instr} !== exp_e) begin n_bad++; $display("FAIL ro_sb: got %h want %h", {instr_pc, instr}, exp_e); end
                end
                done = (sb.size() == 0);
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL ro_timeout: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        run = 1'b1; instr_ready = 1'b1; mem_delay = 0;
        tick();
        n_cmp++; if (imem_ack !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL ra_ack: got %b/%h want 1/0", imem_ack, imem_addr); end
        redirect = 1'b1; redirect_pc = 32'h200;
        sb.push_back({32'h200, mem_word(32'h200)});
        tick();
        redirect = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_bad++; $display("FAIL ra_req: got %b/%h want 1/200", imem_req, imem_addr); end
        n_cmp++; if (pc !== 32'h200 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL ra_pc: got %h v%b want 200 v0", pc, instr_valid); end
        run = 1'b0;
        tick();
        n_cmp++;
        if (!(instr_valid && instr_ready) || sb.size() == 0) begin n_bad++; $display("FAIL ra_sb: got valid %b want 1", instr_valid); end
        else begin
            exp_e = sb.pop_front();
            if ({instr_pc, instr} !== exp_e) begin n_bad++; $display("FAIL ra_sb: got %h want %h", {instr_pc, instr}, exp_e); end
        end
        n_cmp++; if (pc !== 32'h204) begin n_bad++; $display("FAIL ra_pc4: got %h want 204", pc); end
        tick();
    endtask

    task automatic test_fault();
        do_reset();
        run = 1'b1; instr_ready = 1'b1; mem_delay = 3;
        tick();
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        for (int c = 0; c < 6; c++) begin
            n_cmp++;
            if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                n_bad++; $display("FAIL fault_stick c%0d: got f%b r%b v%b want f1 r0 v0", c, fault, imem_req, instr_valid);
            end
            redirect = (c % 2 == 0); redirect_pc = 32'h300; ack_force = (c == 3);
            tick();
        end
        redirect = 1'b0; ack_force = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0; run = 1'b0;
        n_cmp++; if (fault !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0) begin n_bad++; $display("FAIL fault_clear: got f%b r%b %h want f0 r0 0", fault, imem_req, pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        run = 1'b1; instr_ready = 1'b1;
        tick();
        n_cmp++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_req1: got %b/%h want 1/fffffffc", w_req, w_addr); end
        tick();
        n_cmp++; if (w_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC || w_instr !== mem_word(32'hFFFF_FFFC)) begin
            n_bad++; $display("FAIL wrap_instr: got v%b %h@%h want v1 %h@fffffffc", w_valid, w_instr, w_instr_pc, mem_word(32'hFFFF_FFFC));
        end
        n_cmp++; if (w_pc !== 32'h0 || w_fault !== 1'b0) begin n_bad++; $display("FAIL wrap_pc: got %h f%b want 0 f0", w_pc, w_fault); end
        tick();
        n_cmp++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_req2: got %b/%h want 1/0", w_req, w_addr); end
        run = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        run = 1'b1; instr_ready = 1'b1; mem_delay = 0;
        tick();
        tick();
        n_cmp++; if (instr !== mem_word(32'h0) || instr_valid !== 1'b1) begin n_bad++; $display("FAIL mr_pre: got %h v%b want %h v1", instr, instr_valid, mem_word(32'h0)); end
        mem_delay = 3;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_bad++; $display("FAIL mr_req: got %b/%h want 1/4", imem_req, imem_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0; run = 1'b0; ack_force = 1'b1;
        n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0) begin n_bad++; $display("FAIL mr_rst: got r%b %h %h want r0 0 0", imem_req, imem_addr, pc); end
        n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || fault !== 1'b0) begin
            n_bad++; $display("FAIL mr_rst_instr: got v%b %h@%h f%b want v0 0@0 f0", instr_valid, instr, instr_pc, fault);
        end
        tick();
        ack_force = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b0 || pc !== 32'h0) begin
            n_bad++; $display("FAIL mr_late_ack: got v%b %h r%b %h want v0 0 r0 0", instr_valid, instr, imem_req, pc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_ack();
        test_fault();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish within 100000 ns want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle fetch controller that owns the program counter and sequences reads of the instruction memory. It issues one word-aligned request per instruction, holds the returned word in an instruction register until decode accepts it, then advances the PC by 4. It also applies branch/jump redirects from later stages, including a redirect that arrives while a read is outstanding. It sits between the instruction memory and the decode stage of the multi-cycle RISC core.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  fetch enable; when low, no new request is started.
- redirect  in  1  one-cycle pulse that loads redirect_pc as the next fetch address.
- redirect_pc  in  32  redirect target.
- imem_req  out  1  read request to the instruction memory.
- imem_addr  out  32  read address; always word-aligned and stable while imem_req=1.
- imem_ack  in  1  memory has accepted the read; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word from memory.
- instr_valid  out  1  instr and instr_pc hold a fetched instruction.
- instr  out  32  instruction register.
- instr_pc  out  32  address of instr.
- instr_ready  in  1  decode accepts instr this cycle when instr_valid=1.
- pc  out  32  next fetch address.
- fault  out  1  sticky flag: a misaligned redirect target was received.

## Operation
- States: IDLE, FETCH, HOLD, FAULT.
- IDLE
  - If run=1, go to FETCH with imem_addr <= pc.
- FETCH
  - imem_req=1; imem_req stays high until imem_ack. A request is never withdrawn.
  - On imem_ack with no discard pending: instr <= imem_rdata, instr_pc <= imem_addr, pc <= imem_addr+4, then go to HOLD.
- HOLD
  - instr_valid=1.
  - On instr_ready: go to FETCH with imem_addr <= pc if run=1; otherwise go to IDLE.
- Redirect with redirect_pc[1:0]=0 (aligned)
  - pc <= redirect_pc and instr_valid drops next cycle, in any state other than FAULT.
  - IDLE or HOLD: go to FETCH at redirect_pc if run=1, else IDLE. If instr_ready arrives in the same cycle as the redirect, the instruction counts as consumed, but the next fetch still uses redirect_pc.
  - FETCH with imem_ack in the same cycle: the returned word is dropped, and the next state is FETCH at redirect_pc, or IDLE if run=0.
  - FETCH without imem_ack: set a discard flag and keep imem_req/imem_addr unchanged. On the ack, drop the data, clear the flag, and go to FETCH at pc or to IDLE.
  - A second redirect while the discard flag is set overwrites pc; last redirect wins.
- Redirect with redirect_pc[1:0]!=0 (misaligned)
  - Go to FAULT: fault=1, imem_req=0, instr_valid=0.
  - If a read is outstanding, it is abandoned. The memory must tolerate this; this is the only case where a request is dropped.
  - FAULT is left only through reset. redirect and run are ignored in FAULT.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0 with no flag.
- run=0 never interrupts a FETCH in progress or a held instruction. It only blocks starting the next request.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fault=0, discard flag=0.
- Reset overrides every other input in the same edge, including in the middle of a fetch. An in-flight ack after reset is ignored.
- First request: imem_req rises the cycle after run is first sampled high in IDLE.
- imem_ack in cycle N gives instr_valid=1 in cycle N+1.
- instr_ready in cycle M gives imem_req=1 in cycle M+1.
- With ack and ready both held high, throughput is 1 instruction per 2 cycles.
- Redirect in cycle R with no outstanding read gives imem_req at redirect_pc in cycle R+1.
- Redirect in cycle R with an outstanding read: after the discarded ack in cycle A, the new request is issued in cycle A+1.
- All outputs come from registers except imem_req, which decodes from the state register only (no input-to-output combinational path).

## Test plan
- Basic fetch: reset, RESET_PC=0, run=1, memory acks every cycle, ready always high -> requests to 0x0, 0x4, 0x8 in cycles 1, 3, 5; instr_pc matches each address; instr_valid is high in cycles 2, 4, 6.
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc and instr_valid stay stable; no imem_req until 1 cycle after ready rises.
- Redirect during outstanding read: ack delayed by 3 cycles; redirect to 0x100 in the first wait cycle -> imem_addr stays at the old address until ack; that word never appears on instr; the next request goes to 0x100.
- Redirect with simultaneous ack -> the returned word is dropped; the next request is to redirect_pc; pc=redirect_pc (the new target, not the old address plus 4).
- Wrap and fault:
  - RESET_PC=32'hFFFF_FFFC -> the second request goes to 0x0.
  - redirect_pc=0x102 -> fault=1 and imem_req=0 permanently, until reset clears fault in one cycle.
- Mid-operation reset: assert reset while imem_req=1 -> the next cycle shows all outputs at their reset values, and a late ack is ignored.
